// File: rtl/seg_reg_elastic.sv
// seg_reg_elastic
//   Elastic pipeline segment register: a valid/ready stage backed by a
//   2-entry skid buffer (main entry M at the head, skid entry S behind it).
//   Sustains one transfer per cycle. in_ready comes straight from a flop, so
//   the downstream stall never reaches upstream combinationally. When the
//   stage is empty, out_data shows the BUBBLE_VAL (NOP) payload.
//
//   Optional feature: define SEG_PERF_CNT_EN to build the saturating
//   stall/flush performance counters. Without it, both counters are tied to 0.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   flush      kill every held entry this cycle
//   in_valid   upstream payload valid
//   in_ready   stage can accept (registered)
//   in_data    upstream payload [DATA_W]
//   out_valid  downstream payload valid
//   out_ready  downstream accepts
//   out_data   head payload, or BUBBLE_VAL when empty [DATA_W]
//   occupancy  entries held, 0..2
//   stall_cnt  cycles with out_valid & !out_ready [CNT_W]
//   flush_cnt  flushes that killed at least one entry [CNT_W]
module seg_reg_elastic #(
    parameter int DATA_W     = 32,
    parameter     BUBBLE_VAL = 32'h0000_0033,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [DATA_W-1:0] BUBBLE = DATA_W'(BUBBLE_VAL);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_p1, state_nxt;
    logic [DATA_W-1:0] m_data_p1, m_data_nxt;
    logic [DATA_W-1:0] s_data_p1, s_data_nxt;
    logic              rdy_p1;
    logic              m_vld_p1, s_vld_p1;
    logic              accept, pop;

    assign m_vld_p1  = (state_p1 != EMPTY);
    assign s_vld_p1  = (state_p1 == FULL);
    assign accept    = in_valid & rdy_p1;
    assign pop       = m_vld_p1 & out_ready;

    assign in_ready  = rdy_p1;
    assign out_valid = m_vld_p1;
    assign out_data  = m_vld_p1 ? m_data_p1 : BUBBLE;
    assign occupancy = {1'b0, m_vld_p1} + {1'b0, s_vld_p1};

    // Next state: flush overrides everything; an accept in the flush cycle
    // is dropped, while a pop in that cycle has already been taken downstream.
    always_comb begin
        state_nxt  = state_p1;
        m_data_nxt = m_data_p1;
        s_data_nxt = s_data_p1;
        if (flush) begin
            state_nxt  = EMPTY;
            m_data_nxt = BUBBLE;
            s_data_nxt = BUBBLE;
        end else begin
            case (state_p1)
                EMPTY: begin
                    if (accept) begin
                        state_nxt  = ONE;
                        m_data_nxt = in_data;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        m_data_nxt = in_data;
                    end else if (accept) begin
                        state_nxt  = FULL;
                        s_data_nxt = in_data;
                    end else if (pop) begin
                        state_nxt  = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_nxt  = ONE;
                        m_data_nxt = s_data_p1;
                        s_data_nxt = BUBBLE;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // Stage register: in_ready is held low through reset and otherwise
    // tracks "next state is not FULL", i.e. !S.valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1  <= EMPTY;
            m_data_p1 <= BUBBLE;
            s_data_p1 <= BUBBLE;
            rdy_p1    <= 1'b0;
        end else begin
            state_p1  <= state_nxt;
            m_data_p1 <= m_data_nxt;
            s_data_p1 <= s_data_nxt;
            rdy_p1    <= (state_nxt != FULL);
        end
    end

`ifdef SEG_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_p1, flush_cnt_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Performance counters: saturate at all-ones, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_p1 <= '0;
            flush_cnt_p1 <= '0;
        end else begin
            if (out_valid && !out_ready && !flush)
                stall_cnt_p1 <= sat_inc(stall_cnt_p1);
            if (flush && (occupancy != 2'd0))
                flush_cnt_p1 <= sat_inc(flush_cnt_p1);
        end
    end

    assign stall_cnt = stall_cnt_p1;
    assign flush_cnt = flush_cnt_p1;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_seg_reg_elastic.sv
// tb_seg_reg_elastic
//   Bench for seg_reg_elastic (DATA_W=32, CNT_W=4). A queue holds the
//   payloads the stage should currently contain; every cycle the DUT outputs
//   are compared against it, and popped entries are compared in order.
//   Counter expectations follow SEG_PERF_CNT_EN when it is defined.
module tb_seg_reg_elastic;

    localparam int          DATA_W = 32;
    localparam int          CNT_W  = 4;
    localparam logic [31:0] BUBBLE = 32'h0000_0033;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    always #5 clk = ~clk;

    seg_reg_elastic #(
        .DATA_W     (DATA_W),
        .BUBBLE_VAL (32'h0000_0033),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic [1:0]  exp_occ;
    } vec_t;

    vec_t             tbl[13];
    logic [31:0]      sb[$];
    logic [CNT_W-1:0] exp_stall;
    logic [CNT_W-1:0] exp_flush;
    int               nchk = 0;
    int               nerr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_cnt();
`ifdef SEG_PERF_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        chk("flush_cnt", 64'(flush_cnt), 64'(exp_flush));
`else
        chk("stall_cnt_off", 64'(stall_cnt), 64'd0);
        chk("flush_cnt_off", 64'(flush_cnt), 64'd0);
`endif
    endtask

    // One clock cycle: drive inputs, check outputs against the queue model,
    // update the model for this edge, then advance past the edge.
    task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
        bit rdy;
        bit vld;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        rdy = (sb.size() < 2);
        vld = (sb.size() != 0);
        chk("out_valid", 64'(out_valid), 64'(vld));
        chk("occupancy", 64'(occupancy), 64'(sb.size()));
        chk("in_ready", 64'(in_ready), 64'(rdy));
        if (vld) chk("out_data", 64'(out_data), 64'(sb[0]));
        else     chk("out_data_bubble", 64'(out_data), 64'(BUBBLE));
        chk_cnt();
        if (vld && !ordy && !fl && exp_stall != '1) exp_stall++;
        if (fl && vld && exp_flush != '1) exp_flush++;
        if (vld && ordy) void'(sb.pop_front());
        if (iv && rdy) sb.push_back(d);
        if (fl) sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'(BUBBLE));
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_stall = '0;
        exp_flush = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // streaming, out_ready=1
        tbl[0]  = '{1'b1, 32'd1, 1'b1, 1'b0, 2'd1};
        tbl[1]  = '{1'b1, 32'd2, 1'b1, 1'b0, 2'd1};
        tbl[2]  = '{1'b1, 32'd3, 1'b1, 1'b0, 2'd1};
        tbl[3]  = '{1'b1, 32'd4, 1'b1, 1'b0, 2'd1};
        tbl[4]  = '{1'b0, 32'd0, 1'b1, 1'b0, 2'd0};
        tbl[5]  = '{1'b0, 32'd0, 1'b1, 1'b0, 2'd0};
        // skid fill with A,B while C is offered, then drain
        tbl[6]  = '{1'b1, 32'hA000_000A, 1'b0, 1'b0, 2'd1};
        tbl[7]  = '{1'b1, 32'hB000_000B, 1'b0, 1'b0, 2'd2};
        tbl[8]  = '{1'b1, 32'hC000_000C, 1'b0, 1'b0, 2'd2};
        tbl[9]  = '{1'b1, 32'hC000_000C, 1'b0, 1'b0, 2'd2};
        tbl[10] = '{1'b1, 32'hC000_000C, 1'b1, 1'b0, 2'd1};
        tbl[11] = '{1'b1, 32'hC000_000C, 1'b1, 1'b0, 2'd1};
        tbl[12] = '{1'b0, 32'd0,         1'b1, 1'b0, 2'd0};

        exp_stall = '0;
        exp_flush = '0;

        // Reset and empty idle state
        do_reset();
        chk("t1_in_ready", 64'(in_ready), 64'd1);
        chk("t1_out_valid", 64'(out_valid), 64'd0);
        chk("t1_out_data", 64'(out_data), 64'h33);
        chk("t1_occupancy", 64'(occupancy), 64'd0);

        // Streaming and skid fill/drain from the table
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
            chk($sformatf("tbl_occ[%0d]", i), 64'(occupancy), 64'(tbl[i].exp_occ));
        end

        // Flush while FULL with D offered
        step(1'b1, 32'hA1, 1'b0, 1'b0);
        step(1'b1, 32'hB1, 1'b0, 1'b0);
        step(1'b1, 32'hD1, 1'b0, 1'b1);
        chk("t4_out_valid", 64'(out_valid), 64'd0);
        chk("t4_out_data", 64'(out_data), 64'(BUBBLE));
        chk("t4_occupancy", 64'(occupancy), 64'd0);
        repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0);

        // Flush in ONE while accepting: the accepted word is dropped
        step(1'b1, 32'hE1, 1'b0, 1'b0);
        step(1'b1, 32'hF1, 1'b0, 1'b1);
        repeat (2) step(1'b0, 32'd0, 1'b1, 1'b0);

        // Flush coinciding with pop
        do_reset();
        step(1'b1, 32'h5555_AAAA, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        chk("t5_occupancy", 64'(occupancy), 64'd0);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
`ifdef SEG_PERF_CNT_EN
        chk("t5_flush_cnt", 64'(flush_cnt), 64'd1);
`else
        chk("t5_flush_cnt", 64'(flush_cnt), 64'd0);
`endif
        step(1'b0, 32'd0, 1'b1, 1'b0);

        // Stall counter saturation
        do_reset();
        step(1'b1, 32'h0BAD_F00D, 1'b0, 1'b0);
        repeat (20) step(1'b0, 32'd0, 1'b0, 1'b0);
`ifdef SEG_PERF_CNT_EN
        chk("t6_stall_sat", 64'(stall_cnt), 64'd15);
`else
        chk("t6_stall_off", 64'(stall_cnt), 64'd0);
`endif
        step(1'b0, 32'd0, 1'b1, 1'b0);

        // Random traffic with occasional flushes
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(1)), $urandom, 1'($urandom_range(3) != 0),
                 1'($urandom_range(15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
